// File: rtl/codma_copy_engine.sv
// codma_copy_engine: burst memory-to-memory copy engine (read burst, then write burst).
// Ports: clk_i/reset_n_i (async low); start_i/src_addr_i/dst_addr_i/len_i control;
//   busy_o/done_o/error_o status; bus_read_o/bus_write_o/bus_addr_o/bus_size_o/
//   bus_grant_i request; bus_read_data_i/bus_read_valid_i/bus_write_data_o/
//   bus_write_valid_o/bus_error_i data. Macro CODMA_CE_BURST4_EN: 4-beat bursts.
module codma_copy_engine #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              bus_read_o,
  output logic              bus_write_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_size_o,
  input  logic              bus_grant_i,
  input  logic [63:0]       bus_read_data_i,
  input  logic              bus_read_valid_i,
  output logic [63:0]       bus_write_data_o,
  output logic              bus_write_valid_o,
  input  logic              bus_error_i
);

`ifdef CODMA_CE_BURST4_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 2;
`endif
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_REQ,
    WR_DATA,
    ERR
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  rem_q;
  logic [2:0]        beat_q;
  logic [63:0]       buf_q [DEPTH];
  logic              done_q;
  logic              err_q;

  logic              hit4;
  logic              hit2;
  logic [2:0]        beats;
  logic [3:0]        size;
  logic              last_beat;
  logic              misaligned;
  logic              final_burst;
  logic [ADDR_W-1:0] step;

  assign misaligned = (src_addr_i[2:0] != 3'd0) ||
                      (dst_addr_i[2:0] != 3'd0);

  // Burst length follows the remaining count, capped by buffer depth.
  assign hit4 = (DEPTH == 4) && (rem_q >= LEN_W'(4));
  assign hit2 = !hit4 && (rem_q >= LEN_W'(2));

  always_comb begin
    beats = 3'd1;
    size  = 4'd3;
    unique case (1'b1)
      hit4: begin
        beats = 3'd4;
        size  = 4'd9;
      end
      hit2: begin
        beats = 3'd2;
        size  = 4'd8;
      end
      default: ;
    endcase
  end

  assign last_beat   = (beat_q == beats - 3'd1);
  assign final_burst = (rem_q == LEN_W'(beats));
  assign step        = ADDR_W'({beats, 3'b000});

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (misaligned) begin
            state_d = ERR;
          end else if (len_i != '0) begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (bus_grant_i) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (bus_error_i) begin
          state_d = ERR;
        end else if (bus_read_valid_i && last_beat) begin
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (bus_grant_i) state_d = WR_DATA;
      end
      WR_DATA: begin
        if (bus_error_i) begin
          state_d = ERR;
        end else if (last_beat) begin
          state_d = final_burst ? IDLE : RD_REQ;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      src_q  <= '0;
      dst_q  <= '0;
      rem_q  <= '0;
      beat_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            err_q <= misaligned;
            if (!misaligned) begin
              src_q  <= src_addr_i;
              dst_q  <= dst_addr_i;
              rem_q  <= len_i;
              done_q <= (len_i == '0);
            end
          end
        end
        RD_REQ, WR_REQ: beat_q <= '0;
        RD_DATA: begin
          if (bus_error_i) begin
            err_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
          end else if (bus_read_valid_i) begin
            buf_q[beat_q[IDX_W-1:0]] <= bus_read_data_i;
            beat_q <= beat_q + 3'd1;
          end
        end
        WR_DATA: begin
          if (bus_error_i) begin
            err_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
          end else begin
            beat_q <= beat_q + 3'd1;
            if (last_beat) begin
              src_q  <= src_q + step;
              dst_q  <= dst_q + step;
              rem_q  <= rem_q - LEN_W'(beats);
              done_q <= final_burst;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_read_o        = 1'b0;
    bus_write_o       = 1'b0;
    bus_addr_o        = '0;
    bus_size_o        = '0;
    bus_write_valid_o = 1'b0;
    bus_write_data_o  = '0;
    unique case (state_q)
      RD_REQ: begin
        bus_read_o = 1'b1;
        bus_addr_o = src_q;
        bus_size_o = size;
      end
      WR_REQ: begin
        bus_write_o = 1'b1;
        bus_addr_o  = dst_q;
        bus_size_o  = size;
      end
      WR_DATA: begin
        bus_write_valid_o = 1'b1;
        bus_write_data_o  = buf_q[beat_q[IDX_W-1:0]];
      end
      default: ;
    endcase
  end

  assign busy_o  = (state_q == RD_REQ) || (state_q == RD_DATA) ||
                   (state_q == WR_REQ) || (state_q == WR_DATA);
  assign done_o  = done_q;
  assign error_o = err_q;

endmodule

// File: tb/tb_codma_copy_engine.sv
// tb_codma_copy_engine: directed + random copies against a 16-dword memory slave
// and a burst/memory reference model.
module tb_codma_copy_engine;
  localparam int AW = 32;
  localparam int LW = 8;
`ifdef CODMA_CE_BURST4_EN
  localparam int MAXB = 4;
`else
  localparam int MAXB = 2;
`endif

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          start_i;
  logic [AW-1:0] src_addr_i;
  logic [AW-1:0] dst_addr_i;
  logic [LW-1:0] len_i;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic          bus_read_o;
  logic          bus_write_o;
  logic [AW-1:0] bus_addr_o;
  logic [3:0]    bus_size_o;
  logic          bus_grant_i;
  logic [63:0]   bus_read_data_i;
  logic          bus_read_valid_i;
  logic [63:0]   bus_write_data_o;
  logic          bus_write_valid_o;
  logic          bus_error_i;

  always #5 clk_i = ~clk_i;

  codma_copy_engine #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .start_i(start_i),
    .src_addr_i(src_addr_i),
    .dst_addr_i(dst_addr_i),
    .len_i(len_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .error_o(error_o),
    .bus_read_o(bus_read_o),
    .bus_write_o(bus_write_o),
    .bus_addr_o(bus_addr_o),
    .bus_size_o(bus_size_o),
    .bus_grant_i(bus_grant_i),
    .bus_read_data_i(bus_read_data_i),
    .bus_read_valid_i(bus_read_valid_i),
    .bus_write_data_o(bus_write_data_o),
    .bus_write_valid_o(bus_write_valid_o),
    .bus_error_i(bus_error_i)
  );

  logic [63:0]   mem  [16];
  logic [63:0]   refm [16];
  logic [AW-1:0] rd_addr_q [$];
  logic [AW-1:0] wr_addr_q [$];
  int            rd_size_q [$];
  int            wr_size_q [$];
  int            done_cnt, busy_cnt, both_cnt, gap_cnt;
  int            rd_pend, wr_pend;
  logic [AW-1:0] rd_a, wr_a;
  int            nerr = 0;
  int            nchk = 0;

  function automatic int sz2b(input int s);
    if (s == 9) return 4;
    if (s == 8) return 2;
    if (s == 3) return 1;
    return 0;
  endfunction

  // Memory slave: random grant/valid timing, error on writes beyond 0x7F.
  initial begin
    bus_grant_i      = 1'b0;
    bus_read_valid_i = 1'b0;
    bus_read_data_i  = '0;
    bus_error_i      = 1'b0;
    rd_pend = 0;
    wr_pend = 0;
    rd_a = '0;
    wr_a = '0;
    forever begin
      @(negedge clk_i);
      bus_grant_i      = 1'b0;
      bus_read_valid_i = 1'b0;
      bus_error_i      = 1'b0;
      if (!reset_n_i) begin
        rd_pend = 0;
        wr_pend = 0;
      end else begin
        if (done_o) done_cnt++;
        if (busy_o) busy_cnt++;
        if (bus_read_o && bus_write_o) both_cnt++;
        if (rd_pend > 0 && !bus_read_o && $urandom_range(3) != 0) begin
          bus_read_valid_i = 1'b1;
          bus_read_data_i  = (rd_a < 128) ? mem[rd_a[6:3]] : 64'd0;
          rd_a = rd_a + 8;
          rd_pend--;
        end
        if (wr_pend > 0) begin
          if (!bus_write_valid_o) begin
            gap_cnt++;
          end else if (wr_a >= 128) begin
            bus_error_i = 1'b1;
            wr_pend = 0;
          end else begin
            mem[wr_a[6:3]] = bus_write_data_o;
            wr_a = wr_a + 8;
            wr_pend--;
          end
        end
        if (bus_read_o && rd_pend == 0 && $urandom_range(1) == 1) begin
          bus_grant_i = 1'b1;
          rd_addr_q.push_back(bus_addr_o);
          rd_size_q.push_back(int'(bus_size_o));
          rd_pend = sz2b(int'(bus_size_o));
          rd_a = bus_addr_o;
        end
        if (bus_write_o && wr_pend == 0 && $urandom_range(1) == 1) begin
          bus_grant_i = 1'b1;
          wr_addr_q.push_back(bus_addr_o);
          wr_size_q.push_back(int'(bus_size_o));
          wr_pend = sz2b(int'(bus_size_o));
          wr_a = bus_addr_o;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_addr_q.delete();
    wr_addr_q.delete();
    rd_size_q.delete();
    wr_size_q.delete();
    done_cnt = 0;
    busy_cnt = 0;
    both_cnt = 0;
    gap_cnt  = 0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) begin
      mem[i]  = {$urandom, $urandom};
      refm[i] = mem[i];
    end
  endtask

  task automatic do_start(input int s, input int d, input int n);
    @(negedge clk_i);
    start_i    = 1'b1;
    src_addr_i = AW'(s);
    dst_addr_i = AW'(d);
    len_i      = LW'(n);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk_i);
      if (done_cnt > 0 || error_o) break;
    end
    chk({tag, "_timeout"}, 64'(k < 400), 64'd1);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic run_copy(input string tag, input int s, input int d,
                          input int n, input bit poke);
    int r, a, b, nb, k;
    fill_mem();
    for (int i = 0; i < n; i++) refm[d / 8 + i] = refm[s / 8 + i];
    clear_logs();
    do_start(s, d, n);
    chk({tag, "_err_clr"}, 64'(error_o), 64'd0);
    if (poke) begin
      repeat (2) @(negedge clk_i);
      do_start(s + 8, d + 16, 2);
    end
    wait_end(tag);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_error"}, 64'(error_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_rdwr_both"}, 64'(both_cnt), 64'd0);
    chk({tag, "_wr_gap"}, 64'(gap_cnt), 64'd0);
    r = n;
    a = s;
    b = d;
    k = 0;
    while (r > 0) begin
      nb = (r >= MAXB) ? MAXB : ((r >= 2) ? 2 : 1);
      if (k < rd_addr_q.size() && k < wr_addr_q.size()) begin
        chk($sformatf("%s_rd_addr%0d", tag, k), 64'(rd_addr_q[k]), 64'(a));
        chk($sformatf("%s_rd_size%0d", tag, k), 64'(rd_size_q[k]),
            64'((nb == 4) ? 9 : ((nb == 2) ? 8 : 3)));
        chk($sformatf("%s_wr_addr%0d", tag, k), 64'(wr_addr_q[k]), 64'(b));
        chk($sformatf("%s_wr_size%0d", tag, k), 64'(wr_size_q[k]),
            64'((nb == 4) ? 9 : ((nb == 2) ? 8 : 3)));
      end
      a += 8 * nb;
      b += 8 * nb;
      r -= nb;
      k++;
    end
    chk({tag, "_n_rd"}, 64'(rd_addr_q.size()), 64'(k));
    chk({tag, "_n_wr"}, 64'(wr_addr_q.size()), 64'(k));
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_mem%0d", tag, i), mem[i], refm[i]);
  endtask

  initial begin
    int nrd, nbusy;
    bit hit;
    reset_n_i  = 1'b0;
    start_i    = 1'b0;
    src_addr_i = '0;
    dst_addr_i = '0;
    len_i      = '0;
    clear_logs();
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_error", 64'(error_o), 64'd0);
    chk("rst_read", 64'(bus_read_o), 64'd0);
    chk("rst_write", 64'(bus_write_o), 64'd0);
    chk("rst_addr", 64'(bus_addr_o), 64'd0);
    chk("rst_size", 64'(bus_size_o), 64'd0);
    chk("rst_wvalid", 64'(bus_write_valid_o), 64'd0);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    run_copy("len4", 'h00, 'h40, 4, 1'b0);
    run_copy("len7", 'h00, 'h40, 7, 1'b0);
    run_copy("len1", 'h18, 'h58, 1, 1'b0);

    clear_logs();
    do_start('h04, 'h40, 2);
    repeat (4) @(negedge clk_i);
    chk("mis_error", 64'(error_o), 64'd1);
    chk("mis_nrd", 64'(rd_addr_q.size()), 64'd0);
    chk("mis_busy", 64'(busy_cnt), 64'd0);
    chk("mis_done", 64'(done_cnt), 64'd0);

    clear_logs();
    do_start('h00, 'h40, 0);
    chk("len0_done_now", 64'(done_o), 64'd1);
    chk("len0_err_clr", 64'(error_o), 64'd0);
    repeat (3) @(negedge clk_i);
    chk("len0_done_cnt", 64'(done_cnt), 64'd1);
    chk("len0_busy", 64'(busy_cnt), 64'd0);
    chk("len0_nrd", 64'(rd_addr_q.size()), 64'd0);

    fill_mem();
    clear_logs();
    do_start('h00, 'h70, 4);
    wait_end("werr");
    chk("werr_error", 64'(error_o), 64'd1);
    chk("werr_done", 64'(done_cnt), 64'd0);
    chk("werr_busy", 64'(busy_o), 64'd0);
    chk("werr_mem14", mem[14], refm[0]);
    chk("werr_mem15", mem[15], refm[1]);
    run_copy("after_err", 'h00, 'h40, 2, 1'b0);

    clear_logs();
    do_start('h00, 'h40, 4);
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk_i);
      hit = (rd_pend > 0) && !bus_read_o;
    end
    chk("rst_mid_reach", 64'(hit), 64'd1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("rstm_read", 64'(bus_read_o), 64'd0);
    chk("rstm_write", 64'(bus_write_o), 64'd0);
    chk("rstm_wvalid", 64'(bus_write_valid_o), 64'd0);
    chk("rstm_addr", 64'(bus_addr_o), 64'd0);
    chk("rstm_size", 64'(bus_size_o), 64'd0);
    chk("rstm_busy", 64'(busy_o), 64'd0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    nrd   = rd_addr_q.size();
    nbusy = busy_cnt;
    repeat (20) @(negedge clk_i);
    chk("rstm_no_req", 64'(rd_addr_q.size()), 64'(nrd));
    chk("rstm_no_busy", 64'(busy_cnt), 64'(nbusy));
    chk("rstm_no_done", 64'(done_cnt), 64'd0);

    run_copy("restart", 'h00, 'h40, 4, 1'b1);

    for (int t = 0; t < 6; t++) begin
      run_copy($sformatf("rnd%0d", t), 8 * $urandom_range(0, 3),
               8 * $urandom_range(8, 11), $urandom_range(1, 4), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
